// File: rtl/fizzbuzz_formatter.sv
// fizzbuzz_formatter: turns a captured BCD count into its FizzBuzz text line over a valid/ready byte stream
module fizzbuzz_formatter #(
  parameter int DIGITS = 2,
  parameter bit EOL_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_go,
  input  logic [DIGITS*4-1:0]   i_bcd,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);
  localparam int SW = $clog2(DIGITS*9+1);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [2:0] {IDLE, SEL, WORD, DIG, CR, LF, DONE} state_t;
  state_t state;
  logic [DIGITS*4-1:0] bcd_q;
  logic [1:0] mod3_q, mod3;
  logic div5_q, zero_q, zero;
  logic [DW-1:0] msd_q, msd, didx;
  logic [SW-1:0] sum;
  logic [2:0] widx, wend, t;
  logic xfer, last;
  function automatic logic [7:0] word(input logic [2:0] i);
    return i == 3'd0 ? "F" : i == 3'd1 ? "i" : i == 3'd4 ? "B" : i == 3'd5 ? "u" : "z";
  endfunction
  function automatic logic [7:0] digit(input logic [DIGITS*4-1:0] b, input logic [DW-1:0] i);
    return {4'h3, b[4*i +: 4]};
  endfunction
  // classify the incoming count: digit sum folded mod 3 bit-serially, most significant nonzero digit, all-zero flag
  always_comb begin
    sum = '0;
    msd = '0;
    zero = 1'b1;
    mod3 = '0;
    t = '0;
    for (int k = 0; k < DIGITS; k++) begin
      sum = sum + SW'(i_bcd[4*k +: 4]);
      if (i_bcd[4*k +: 4] != 4'd0) begin
        msd = DW'(k);
        zero = 1'b0;
      end
    end
    for (int k = SW-1; k >= 0; k--) begin
      t = {mod3, sum[k]};
      mod3 = t >= 3'd3 ? 2'(t - 3'd3) : t[1:0];
    end
  end
  assign xfer = o_valid && i_ready;
  assign last = (state == WORD && widx == wend) || (state == DIG && didx == '0);
  // line sequencer: capture, select content, stream bytes, optional CR LF, release
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      o_data <= '0;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      bcd_q <= '0;
      mod3_q <= '0;
      div5_q <= 1'b0;
      zero_q <= 1'b0;
      msd_q <= '0;
      widx <= '0;
      wend <= '0;
      didx <= '0;
    end else begin
      case (state)
        IDLE: if (i_go) begin
          bcd_q <= i_bcd;
          mod3_q <= mod3;
          div5_q <= i_bcd[3:0] == 4'd0 || i_bcd[3:0] == 4'd5;
          zero_q <= zero;
          msd_q <= msd;
          o_busy <= 1'b1;
          state <= SEL;
        end
        SEL: begin
          o_valid <= 1'b1;
          if (zero_q || (mod3_q != 2'd0 && !div5_q)) begin
            state <= DIG;
            didx <= msd_q;
            o_data <= digit(bcd_q, msd_q);
          end else begin
            state <= WORD;
            widx <= mod3_q == 2'd0 ? 3'd0 : 3'd4;
            wend <= div5_q ? 3'd7 : 3'd3;
            o_data <= mod3_q == 2'd0 ? "F" : "B";
          end
        end
        WORD, DIG: if (xfer) begin
          if (last && EOL_EN) begin
            state <= CR;
            o_data <= 8'h0D;
          end else if (last) begin
            state <= DONE;
            o_data <= '0;
            o_valid <= 1'b0;
            o_busy <= 1'b0;
          end else if (state == WORD) begin
            widx <= widx + 3'd1;
            o_data <= word(widx + 3'd1);
          end else begin
            didx <= didx - 1'b1;
            o_data <= digit(bcd_q, didx - 1'b1);
          end
        end
        CR: if (xfer) begin
          state <= LF;
          o_data <= 8'h0A;
        end
        LF: if (xfer) begin
          state <= DONE;
          o_data <= '0;
          o_valid <= 1'b0;
          o_busy <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fizzbuzz_formatter.sv
// tb_fizzbuzz_formatter: randomized scoreboard bench for fizzbuzz_formatter with and without line terminator
module tb_fizzbuzz_formatter;
  logic clk = 1'b0, rst = 1'b1, ready = 1'b1;
  logic [7:0] bcd = '0;
  logic go0 = 1'b0, go1 = 1'b0;
  logic [7:0] d0, d1, pd0;
  logic v0, v1, b0, b1;
  logic st0 = 1'b0;
  bit rmode = 1'b0;
  int errors = 0, checks = 0, pops0 = 0;
  logic [7:0] q0[$], q1[$];

  always #5 clk = ~clk;

  fizzbuzz_formatter #(.DIGITS(2), .EOL_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .i_go(go0), .i_bcd(bcd),
    .o_data(d0), .o_valid(v0), .i_ready(ready), .o_busy(b0));

  fizzbuzz_formatter #(.DIGITS(2), .EOL_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .i_go(go1), .i_bcd(bcd),
    .o_data(d1), .o_valid(v1), .i_ready(ready), .o_busy(b1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: FizzBuzz rules on the decimal value, zero printed as "0"
  task automatic expect_line(input int w, input int n);
    string s;
    if (n == 0) s = "0";
    else if (n % 15 == 0) s = "FizzBuzz";
    else if (n % 3 == 0) s = "Fizz";
    else if (n % 5 == 0) s = "Buzz";
    else s = $sformatf("%0d", n);
    for (int i = 0; i < s.len(); i++)
      if (w == 0) q0.push_back(s[i]); else q1.push_back(s[i]);
    if (w == 0) begin
      q0.push_back(8'h0D);
      q0.push_back(8'h0A);
    end
  endtask

  // monitor: scoreboard pops, hold-while-stalled and zero-data-when-idle checks
  always @(negedge clk) begin
    if (!rst) begin
      if (st0) chk("stall_hold0", {v0, d0}, {1'b1, pd0});
      if (!v0) chk("idle_data0", d0, 0);
      if (!v1) chk("idle_data1", d1, 0);
      if (v0 && ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte0: got %0h expected none", d0);
        end else chk("byte0", d0, q0.pop_front());
        pops0++;
      end
      if (v1 && ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte1: got %0h expected none", d1);
        end else chk("byte1", d1, q1.pop_front());
      end
    end
    st0 = v0 && !ready && !rst;
    pd0 = d0;
  end

  initial forever begin
    @(posedge clk);
    #2;
    ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic rnd_bcd();
    bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endtask

  task automatic wait_idle(input int w, input bit tcyc, input int len);
    int cyc = 0, first = -1;
    while ((w == 0 ? b0 : b1) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (first < 0 && (w == 0 ? v0 : v1)) first = cyc;
    end
    if (cyc >= 1000) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d cycles expected busy to fall", cyc);
    end
    chk("first_valid_cycle", first, 1);
    if (tcyc) chk("busy_cycles", cyc, len + 1);
    chk("queue_drained", w == 0 ? q0.size() : q1.size(), 0);
  endtask

  task automatic line(input int w, input int n, input bit tcyc);
    int len;
    bcd = {4'(n / 10), 4'(n % 10)};
    expect_line(w, n);
    len = w == 0 ? q0.size() : q1.size();
    if (w == 0) go0 = 1'b1; else go1 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b0; go1 = 1'b0;
    rnd_bcd();
    wait_idle(w, tcyc, len);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base, cyc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", v0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_data", d0, 0);
    @(posedge clk); #1;
    line(0, 3, 1); line(0, 15, 1); line(0, 10, 1); line(0, 99, 1);
    line(0, 7, 1); line(0, 13, 1); line(0, 0, 1);
    line(1, 6, 1); line(1, 15, 1); line(1, 42, 1);
    rmode = 1'b1;
    line(0, 11, 0);
    for (int i = 0; i < 25; i++) line(0, $urandom_range(0, 99), 0);
    for (int i = 0; i < 8; i++) line(1, $urandom_range(0, 99), 0);
    bcd = 8'h13;
    expect_line(0, 13);
    go0 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bcd = 8'h05;
    go0 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b0;
    wait_idle(0, 0, 0);
    @(posedge clk); #1;
    line(0, 5, 0);
    rmode = 1'b0;
    @(posedge clk); #1;
    bcd = 8'h15;
    expect_line(0, 15);
    base = pops0;
    go0 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b0;
    cyc = 0;
    while (pops0 < base + 2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("rst_point_reached", pops0 - base, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", v0, 0);
    chk("midrst_busy", b0, 0);
    chk("midrst_data", d0, 0);
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    line(0, 5, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
